// File: rtl/nn_pkg.sv
// Shared pooling-layer constants: word width, layer codes, per-layer geometry,
// and the signed-max helper used by the pooling datapath.
package nn_pkg;

  localparam int DATSIZE = 22;

  localparam logic [3:0] ST_POOL1 = 4'b0011;
  localparam logic [3:0] ST_POOL2 = 4'b0101;
  localparam logic [3:0] ST_POOL3 = 4'b0111;

  localparam int POOL1_OUT_H = 16;
  localparam int POOL1_OUT_W = 16;
  localparam int POOL1_C     = 16;
  localparam int POOL1_BEATS = 2;
  localparam int POOL2_OUT_H = 8;
  localparam int POOL2_OUT_W = 8;
  localparam int POOL2_C     = 32;
  localparam int POOL2_BEATS = 2;
  localparam int POOL3_OUT_H = 2;
  localparam int POOL3_OUT_W = 2;
  localparam int POOL3_C     = 64;
  localparam int POOL3_BEATS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } pool_fsm_e;

  // Counter limits are held as "last index" so the wrap test is a plain compare.
  typedef struct packed {
    logic [3:0] last_y;
    logic [3:0] last_x;
    logic [5:0] last_c;
    logic [2:0] last_b;
    logic       big;
  } pool_geom_t;

  function automatic logic is_pool(input logic [3:0] code);
    return (code == ST_POOL1) || (code == ST_POOL2) || (code == ST_POOL3);
  endfunction

  function automatic pool_geom_t geom_of(input logic [3:0] code);
    pool_geom_t g;
    g = '0;
    case (code)
      ST_POOL1: begin
        g.last_y = 4'(POOL1_OUT_H - 1);
        g.last_x = 4'(POOL1_OUT_W - 1);
        g.last_c = 6'(POOL1_C - 1);
        g.last_b = 3'(POOL1_BEATS - 1);
        g.big    = 1'b0;
      end
      ST_POOL2: begin
        g.last_y = 4'(POOL2_OUT_H - 1);
        g.last_x = 4'(POOL2_OUT_W - 1);
        g.last_c = 6'(POOL2_C - 1);
        g.last_b = 3'(POOL2_BEATS - 1);
        g.big    = 1'b0;
      end
      ST_POOL3: begin
        g.last_y = 4'(POOL3_OUT_H - 1);
        g.last_x = 4'(POOL3_OUT_W - 1);
        g.last_c = 6'(POOL3_C - 1);
        g.last_b = 3'(POOL3_BEATS - 1);
        g.big    = 1'b1;
      end
      default: g = '0;
    endcase
    return g;
  endfunction

  function automatic logic signed [DATSIZE-1:0] smax(input logic signed [DATSIZE-1:0] a,
                                                     input logic signed [DATSIZE-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool_max_acc.sv
// Window reducer: signed max of a pixel pair folded into a running accumulator.
// acc_vld_o pulses the cycle after the last beat of a window has been folded in.
module pool_max_acc
  import nn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld_i,
  input  logic                      first_i,
  input  logic                      last_i,
  input  logic [2*DATSIZE-1:0]      pair_i,
  output logic signed [DATSIZE-1:0] acc_o,
  output logic                      acc_vld_o
);

  logic signed [DATSIZE-1:0] even_s, odd_s, m_s, acc_d, acc_q;
  logic                      acc_vld_q;

  // Reduce the pair, then seed or fold into the accumulator.
  always_comb begin
    even_s = pair_i[DATSIZE-1:0];
    odd_s  = pair_i[2*DATSIZE-1:DATSIZE];
    m_s    = smax(even_s, odd_s);
    if (!in_vld_i) begin
      acc_d = acc_q;
    end else if (first_i) begin
      acc_d = m_s;
    end else begin
      acc_d = smax(acc_q, m_s);
    end
  end

  // Accumulator and window-complete flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_vld_q <= in_vld_i & last_i;
    end
  end

  assign acc_o     = acc_q;
  assign acc_vld_o = acc_vld_q;

endmodule

// File: rtl/pool_seq.sv
// Max-pool layer sequencer: walks the pool buffer, reduces windows, writes the conv buffer.
// Optional POOL_RELU_EN clamps negative pooled values to zero on the write port.
module pool_seq
  import nn_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   state,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pool_rd_en,
  output logic [3:0]   pool_rd_y,
  output logic [3:0]   pool_rd_x,
  output logic [5:0]   pool_rd_c,
  output logic         pool_rd_updown,
  input  logic [43:0]  pool_rd_data,
  output logic         conv_wr_en,
  output logic [4:0]   conv_wr_y,
  output logic [4:0]   conv_wr_x,
  output logic [5:0]   conv_wr_c,
  output logic [21:0]  conv_wr_data
);

  pool_fsm_e  fsm_q, fsm_d;
  pool_geom_t geom_q, geom_d;
  logic [2:0] b_q, b_d;
  logic [3:0] px_q, px_d, py_q, py_d;
  logic [5:0] c_q, c_d;
  logic       drain_q, drain_d, done_q;
  logic       last_b_s, last_x_s, last_y_s, last_c_s, wrap_all_s, rd_en_s;

  logic       tag_vld_q, tag_first_q, tag_last_q;
  logic [3:0] tag_py_q, tag_px_q, wr_y_q, wr_x_q;
  logic [5:0] tag_c_q, wr_c_q;

  logic signed [DATSIZE-1:0] acc_s;
  logic                      acc_vld_s;

  // State register, layer geometry and read-address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      geom_q  <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
      b_q     <= 3'd0;
      px_q    <= 4'd0;
      py_q    <= 4'd0;
      c_q     <= 6'd0;
    end else begin
      fsm_q   <= fsm_d;
      geom_q  <= geom_d;
      drain_q <= drain_d;
      done_q  <= (fsm_q == S_DONE);
      b_q     <= b_d;
      px_q    <= px_d;
      py_q    <= py_d;
      c_q     <= c_d;
    end
  end

  // Nested beat/px/py/c counters; every counter returns to 0 when the layer wraps.
  always_comb begin
    last_b_s   = (b_q == geom_q.last_b);
    last_x_s   = (px_q == geom_q.last_x);
    last_y_s   = (py_q == geom_q.last_y);
    last_c_s   = (c_q == geom_q.last_c);
    b_d        = b_q;
    px_d       = px_q;
    py_d       = py_q;
    c_d        = c_q;
    wrap_all_s = 1'b0;
    if (fsm_q == S_RUN) begin
      if (last_b_s) begin
        b_d = 3'd0;
        if (last_x_s) begin
          px_d = 4'd0;
          if (last_y_s) begin
            py_d = 4'd0;
            if (last_c_s) begin
              c_d        = 6'd0;
              wrap_all_s = 1'b1;
            end else begin
              c_d = c_q + 6'd1;
            end
          end else begin
            py_d = py_q + 4'd1;
          end
        end else begin
          px_d = px_q + 4'd1;
        end
      end else begin
        b_d = b_q + 3'd1;
      end
    end else begin
      wrap_all_s = 1'b0;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    fsm_d   = fsm_q;
    geom_d  = geom_q;
    drain_d = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          geom_d = geom_of(state);
          fsm_d  = is_pool(state) ? S_RUN : S_DONE;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (wrap_all_s) fsm_d = S_DRAIN;
        else            fsm_d = S_RUN;
      end
      S_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) fsm_d = S_DONE;
        else         fsm_d = S_DRAIN;
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Status and read-address decode; 4x4 windows split the beat into row, updown and column bits.
  always_comb begin
    busy    = (fsm_q != S_IDLE);
    rd_en_s = (fsm_q == S_RUN);
    if (geom_q.big) begin
      pool_rd_y      = {py_q[2:0], b_q[2]};
      pool_rd_x      = {px_q[2:0], b_q[0]};
      pool_rd_updown = b_q[1];
    end else begin
      pool_rd_y      = py_q;
      pool_rd_x      = px_q;
      pool_rd_updown = b_q[0];
    end
  end

  assign pool_rd_en = rd_en_s;
  assign pool_rd_c  = c_q;
  assign done       = done_q;

  // Beat tags follow the read by one cycle to meet its data; write address latched on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q   <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_py_q    <= 4'd0;
      tag_px_q    <= 4'd0;
      tag_c_q     <= 6'd0;
      wr_y_q      <= 4'd0;
      wr_x_q      <= 4'd0;
      wr_c_q      <= 6'd0;
    end else begin
      tag_vld_q   <= rd_en_s;
      tag_first_q <= (b_q == 3'd0);
      tag_last_q  <= last_b_s;
      tag_py_q    <= py_q;
      tag_px_q    <= px_q;
      tag_c_q     <= c_q;
      if (tag_vld_q && tag_last_q) begin
        wr_y_q <= tag_py_q;
        wr_x_q <= tag_px_q;
        wr_c_q <= tag_c_q;
      end else begin
        wr_y_q <= wr_y_q;
        wr_x_q <= wr_x_q;
        wr_c_q <= wr_c_q;
      end
    end
  end

  pool_max_acc u_max_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (tag_vld_q),
    .first_i   (tag_first_q),
    .last_i    (tag_last_q),
    .pair_i    (pool_rd_data),
    .acc_o     (acc_s),
    .acc_vld_o (acc_vld_s)
  );

  assign conv_wr_en = acc_vld_s;
  assign conv_wr_y  = {1'b0, wr_y_q};
  assign conv_wr_x  = {1'b0, wr_x_q};
  assign conv_wr_c  = wr_c_q;
`ifdef POOL_RELU_EN
  assign conv_wr_data = acc_s[DATSIZE-1] ? {DATSIZE{1'b0}} : acc_s;
`else
  assign conv_wr_data = acc_s;
`endif

endmodule
